// File: rtl/conv_frame_collector.sv
// conv_frame_collector
// Captures one frame from the convolution stream (bottom row first, left to right)
// into a frame buffer, then replays it in top-left to bottom-right raster order over
// a valid/ready handshake. One registered-read buffer plus a single prefetch stage
// keeps the replay at one pixel per cycle under continuous outReady.
module conv_frame_collector #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ROW_SIZE  = 538,
    parameter int unsigned NUM_ROWS  = 358
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_SIZE-1:0]        inputPixel,
    input  logic [1:0]                  valid,
    output logic [WORD_SIZE-1:0]        outputPixel,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [$clog2(NUM_ROWS)-1:0] outRow,
    output logic [$clog2(ROW_SIZE)-1:0] outCol,
    output logic                        frameDone,
    output logic                        dropped
);

    localparam int unsigned RW    = $clog2(NUM_ROWS);
    localparam int unsigned CW    = $clog2(ROW_SIZE);
    localparam int unsigned DEPTH = ROW_SIZE * NUM_ROWS;
    localparam int unsigned AW    = $clog2(DEPTH);

    localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(ROW_SIZE - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        StCapture = 1'b0,
        StDrain   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Write side
    logic [RW-1:0] r_wrow;
    logic [CW-1:0] r_wcol;
    logic [AW-1:0] w_waddr;
    logic          w_qual;
    logic          w_wr_en;
    logic          w_row_end;
    logic          w_cap_last;

    // Frame buffer and its registered read port
    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [WORD_SIZE-1:0] r_rdata;
    logic [AW-1:0]        w_raddr;

    // Prefetch pointer: next raster position not yet read from the buffer
    logic          r_pf_valid;
    logic [AW-1:0] r_pf_addr;
    logic [RW-1:0] r_pf_row;
    logic [CW-1:0] r_pf_col;

    // Tag of the word sitting on r_rdata
    logic          r_dat_valid;
    logic [AW-1:0] r_dat_addr;
    logic [RW-1:0] r_dat_row;
    logic [CW-1:0] r_dat_col;

    // Output register
    logic                 r_out_valid;
    logic [WORD_SIZE-1:0] r_out_pixel;
    logic [RW-1:0]        r_out_row;
    logic [CW-1:0]        r_out_col;
    logic                 r_frame_done;
    logic                 r_dropped;

    logic w_hs;
    logic w_last_hs;
    logic w_load;
    logic w_fetch;

    // Only 2'b01 qualifies a pixel; all other codes are idle cycles.
    assign w_qual     = (valid == 2'b01);
    assign w_wr_en    = w_qual && (r_state == StCapture);
    assign w_row_end  = (r_wcol == LAST_COL);
    assign w_cap_last = w_wr_en && w_row_end && (r_wrow == '0);
    assign w_waddr    = AW'(AW'(r_wrow) * AW'(ROW_SIZE)) + AW'(r_wcol);

    assign w_hs      = r_out_valid && outReady;
    assign w_last_hs = w_hs && (r_out_row == LAST_ROW) && (r_out_col == LAST_COL);
    // Output register takes a new word when empty or when its word is being accepted.
    assign w_load    = r_dat_valid && (!r_out_valid || outReady);
    // Fetch the next address when the read word is empty or is being consumed.
    assign w_fetch   = r_pf_valid && (!r_dat_valid || w_load);
    // While stalled, re-read the held address so r_rdata stays put; the buffer is
    // never written during replay, so the re-read is safe.
    assign w_raddr   = w_fetch ? r_pf_addr : r_dat_addr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StCapture;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: capture until the top-right pixel, drain until its handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StCapture: if (w_cap_last) w_state_next = StDrain;
            StDrain:   if (w_last_hs)  w_state_next = StCapture;
        endcase
    end

    // Write counters: bottom row first, columns left to right, rows counting down
    always_ff @(posedge clk) begin
        if (rst || w_last_hs) begin
            r_wrow <= LAST_ROW;
            r_wcol <= '0;
        end else if (w_wr_en) begin
            if (w_row_end) begin
                r_wcol <= '0;
                r_wrow <= r_wrow - RW'(1);
            end else begin
                r_wcol <= r_wcol + CW'(1);
            end
        end
    end

    // Frame buffer: one write port, one registered read port, never cleared
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_waddr] <= inputPixel;
        end
        r_rdata <= r_mem[w_raddr];
    end

    // Prefetch pointer and read-word tag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pf_valid  <= 1'b0;
            r_pf_addr   <= '0;
            r_pf_row    <= '0;
            r_pf_col    <= '0;
            r_dat_valid <= 1'b0;
            r_dat_addr  <= '0;
            r_dat_row   <= '0;
            r_dat_col   <= '0;
        end else if (w_cap_last) begin
            r_pf_valid  <= 1'b1;
            r_pf_addr   <= '0;
            r_pf_row    <= '0;
            r_pf_col    <= '0;
            r_dat_valid <= 1'b0;
        end else if (w_fetch) begin
            r_dat_valid <= 1'b1;
            r_dat_addr  <= r_pf_addr;
            r_dat_row   <= r_pf_row;
            r_dat_col   <= r_pf_col;
            if (r_pf_addr == LAST_ADDR) begin
                r_pf_valid <= 1'b0;
            end else begin
                r_pf_addr <= r_pf_addr + AW'(1);
                if (r_pf_col == LAST_COL) begin
                    r_pf_col <= '0;
                    r_pf_row <= r_pf_row + RW'(1);
                end else begin
                    r_pf_col <= r_pf_col + CW'(1);
                end
            end
        end else if (w_load) begin
            r_dat_valid <= 1'b0;
        end
    end

    // Output register, end-of-frame pulse and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_pixel  <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            r_frame_done <= w_last_hs;
            if (w_qual && (r_state == StDrain)) begin
                r_dropped <= 1'b1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_pixel <= r_rdata;
                r_out_row   <= r_dat_row;
                r_out_col   <= r_dat_col;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign outputPixel = r_out_pixel;
    assign outValid    = r_out_valid;
    assign outRow      = r_out_row;
    assign outCol      = r_out_col;
    assign frameDone   = r_frame_done;
    assign dropped     = r_dropped;

endmodule

// File: tb/tb_conv_frame_collector.sv
// Scoreboard bench for conv_frame_collector (4 columns x 3 rows).
// A frame-level model collects pixels by arrival index, rebuilds the picture and
// queues it in raster order; a negedge monitor pops and compares each handshake.
module tb_conv_frame_collector;

    localparam int WS   = 8;
    localparam int RS   = 4;
    localparam int NR   = 3;
    localparam int NPIX = RS * NR;

    typedef struct {
        logic [7:0] pix;
        logic [1:0] row;
        logic [1:0] col;
        bit         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WS-1:0] inputPixel = '0;
    logic [1:0]    valid = 2'b00;
    logic          outReady = 1'b1;
    logic [WS-1:0] outputPixel;
    logic          outValid;
    logic [1:0]    outRow;
    logic [1:0]    outCol;
    logic          frameDone;
    logic          dropped;

    always #5 clk = ~clk;

    conv_frame_collector #(
        .WORD_SIZE (WS),
        .ROW_SIZE  (RS),
        .NUM_ROWS  (NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inputPixel  (inputPixel),
        .valid       (valid),
        .outputPixel (outputPixel),
        .outValid    (outValid),
        .outReady    (outReady),
        .outRow      (outRow),
        .outCol      (outCol),
        .frameDone   (frameDone),
        .dropped     (dropped)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model state
    exp_t       q[$];
    logic [7:0] m_frame [NPIX];
    int         m_cnt = 0;
    bit         m_drain = 1'b0;
    bit         m_fd = 1'b0;
    bit         m_dropped = 1'b0;
    bit         m_first_pending = 1'b0;
    bit         hs_last_pending = 1'b0;
    int         cycle = 0;
    int         m_cap_cycle = 0;

    // Monitor state
    bit         prev_stall = 1'b0;
    logic [7:0] prev_pix;
    logic [1:0] prev_row;
    logic [1:0] prev_col;
    int         run = 0;
    int         last_run = 0;
    int         n_done = 0;
    int         exp_done = 0;

    int ready_mode = 0;
    int rc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel k of a frame lands at row NR-1-k/RS, column k%RS.
    initial forever begin
        exp_t e;
        @(posedge clk);
        cycle++;
        m_fd = 1'b0;
        if (rst) begin
            q.delete();
            m_cnt = 0;
            m_drain = 1'b0;
            m_dropped = 1'b0;
            m_first_pending = 1'b0;
            hs_last_pending = 1'b0;
        end else begin
            if (valid == 2'b01) begin
                if (m_drain) begin
                    m_dropped = 1'b1;
                end else begin
                    m_frame[(NR - 1 - m_cnt / RS) * RS + (m_cnt % RS)] = inputPixel;
                    m_cnt++;
                    if (m_cnt == NPIX) begin
                        for (int r = 0; r < NR; r++) begin
                            for (int c = 0; c < RS; c++) begin
                                e.pix  = m_frame[r * RS + c];
                                e.row  = 2'(r);
                                e.col  = 2'(c);
                                e.last = (r == NR - 1) && (c == RS - 1);
                                q.push_back(e);
                            end
                        end
                        m_cnt = 0;
                        m_drain = 1'b1;
                        m_first_pending = 1'b1;
                        m_cap_cycle = cycle;
                    end
                end
            end
            if (hs_last_pending) begin
                hs_last_pending = 1'b0;
                m_drain = 1'b0;
                m_fd = 1'b1;
            end
        end
    end

    // Monitor: sample mid-cycle; a handshake here completes at the coming posedge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        chk("dropped", 32'(dropped), 32'(m_dropped));
        chk("frame_done", 32'(frameDone), 32'(m_fd));
        if (frameDone) n_done++;
        if (m_fd) chk("valid_after_last", 32'(outValid), 32'd0);
        if (prev_stall) begin
            chk("stall_hold", 32'({outValid, outputPixel, outRow, outCol}),
                32'({1'b1, prev_pix, prev_row, prev_col}));
        end
        if (outValid && !rst && m_first_pending) begin
            chk("first_latency", 32'(cycle), 32'(m_cap_cycle + 2));
            m_first_pending = 1'b0;
        end
        if (outValid && !rst) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL valid_without_expected: outValid=%0b pixel=0x%0h, expected no output",
                         outValid, outputPixel);
            end else if (outReady) begin
                e = q.pop_front();
                chk("out_pix_row_col", 32'({outputPixel, outRow, outCol}),
                    32'({e.pix, e.row, e.col}));
                if (e.last) hs_last_pending = 1'b1;
            end
        end
        if (outValid) begin
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        prev_stall = outValid && !outReady && !rst;
        prev_pix = outputPixel;
        prev_row = outRow;
        prev_col = outCol;
    end

    // outReady driver: 0 = always high, 1 = 1,0,0,1 pattern, 2 = random
    initial forever begin
        @(posedge clk);
        #1;
        rc++;
        case (ready_mode)
            0:       outReady = 1'b1;
            1:       outReady = ((rc % 4) == 0) || ((rc % 4) == 3);
            default: outReady = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic drive(input logic [1:0] v, input logic [7:0] p);
        @(posedge clk);
        #1;
        valid = v;
        inputPixel = p;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b00, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] base, input bit gaps, input bit rnd);
        logic [1:0] code;
        for (int k = 0; k < NPIX; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    case ($urandom_range(0, 2))
                        0:       code = 2'b00;
                        1:       code = 2'b10;
                        default: code = 2'b11;
                    endcase
                    drive(code, rnd ? 8'($urandom) : 8'hFF);
                end
            end
            drive(2'b01, rnd ? 8'($urandom) : base + 8'(k));
        end
        drive(2'b00, 8'h00);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid = 2'b00;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("reset_outputs",
                32'({outValid, outputPixel, outRow, outCol, frameDone, dropped}), 32'd0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((m_drain || q.size() != 0) && i < 500) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("drain_timeout", 32'(m_drain), 32'd0);
        repeat (2) @(negedge clk);
        exp_done++;
        chk("frame_done_count", 32'(n_done), 32'(exp_done));
    endtask

    initial begin
        int i;
        do_reset(3);

        // Basic reorder, full throughput
        ready_mode = 0;
        send_frame(8'h00, 1'b0, 1'b0);
        wait_drain();
        chk("throughput_run", 32'(last_run), 32'(NPIX));

        // Invalid valid codes interleaved with 0xFF
        send_frame(8'h00, 1'b1, 1'b0);
        wait_drain();

        // Backpressure during drain
        ready_mode = 1;
        send_frame(8'h00, 1'b0, 1'b0);
        wait_drain();

        // Overrun during drain, then a fresh frame
        ready_mode = 0;
        send_frame(8'h50, 1'b0, 1'b0);
        idle(3);
        drive(2'b01, 8'hAA);
        drive(2'b00, 8'h00);
        wait_drain();
        chk("dropped_sticky", 32'(dropped), 32'd1);
        send_frame(8'h10, 1'b0, 1'b0);
        wait_drain();
        chk("dropped_still_set", 32'(dropped), 32'd1);

        // Reset after six inputs, then a fresh frame
        for (int k = 0; k < 6; k++) drive(2'b01, 8'h70 + 8'(k));
        do_reset(2);
        send_frame(8'h20, 1'b0, 1'b0);
        wait_drain();

        // Back-to-back: next frame's first pixel arrives in the frameDone cycle
        send_frame(8'h60, 1'b0, 1'b0);
        i = 0;
        while (!hs_last_pending && i < 500) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("last_handshake_seen", 32'(hs_last_pending), 32'd1);
        exp_done++;
        send_frame(8'h30, 1'b0, 1'b0);
        wait_drain();

        // Randomized frames with gaps and random backpressure
        ready_mode = 2;
        for (int f = 0; f < 4; f++) begin
            send_frame(8'h00, 1'b1, 1'b1);
            wait_drain();
        end

        // Reset in the middle of a drain, then recover
        ready_mode = 1;
        send_frame(8'h80, 1'b0, 1'b0);
        idle(6);
        do_reset(2);
        ready_mode = 2;
        send_frame(8'h00, 1'b1, 1'b1);
        wait_drain();

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_frame_collector.md
# conv_frame_collector

Hardware sink for the `convolution` output stream. It captures one frame of `outputPixel`/`valid` into an internal frame buffer. The pixels arrive in bottom-left to top-right scan order: bottom row first, columns left to right. Once the frame is complete, it replays the frame in top-left to bottom-right raster order over a valid/ready handshake. It replaces the bench-side file dump and sits between `convolution` and the downstream pooling/readout logic.

## Interface
- `WORD_SIZE`, 8, pixel width in bits.
- `ROW_SIZE`, 538, captured pixels per row (columns).
- `NUM_ROWS`, 358, captured rows per frame.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `inputPixel`  in  WORD_SIZE  pixel from `convolution.outputPixel`.
- `valid`  in  2  from `convolution.valid`; only `2'b01` qualifies a pixel; `00`/`10`/`11` are ignored.
- `outputPixel`  out  WORD_SIZE  replayed pixel.
- `outValid`  out  1  `outputPixel`/`outRow`/`outCol` are valid.
- `outReady`  in  1  downstream accepts the current output.
- `outRow`  out  $clog2(NUM_ROWS)  raster row of current output (0 = top).
- `outCol`  out  $clog2(ROW_SIZE)  column of current output.
- `frameDone`  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- `dropped`  out  1  sticky; set when a qualified input arrives outside CAPTURE.

## Operation
- Frame buffer: ROW_SIZE*NUM_ROWS words, one write port, one read port, registered read (1-cycle latency). The buffer is not cleared by reset.
- Address = row*ROW_SIZE + col.
- States: CAPTURE, DRAIN.
- CAPTURE: write row counter `wRow` resets to NUM_ROWS-1; `wCol` resets to 0.
  - Each qualified input writes `inputPixel` to (`wRow`, `wCol`) and advances `wCol`.
  - When `wCol`==ROW_SIZE-1, `wCol` wraps to 0 and `wRow` decrements.
  - A write at (0, ROW_SIZE-1) moves the state to DRAIN.
  - Gaps between qualified inputs are allowed; counters hold.
- DRAIN: read counters start at (0,0), advance column-first, and wrap rows upward to NUM_ROWS-1.
  - One output register, fed by a prefetched read so that back-to-back handshakes sustain 1 pixel/cycle.
  - When `outValid`&&!`outReady`, `outputPixel`, `outRow` and `outCol` hold stable.
  - Handshake of (NUM_ROWS-1, ROW_SIZE-1) ends the frame:
    - next cycle `frameDone`=1 and `outValid`=0;
    - state returns to CAPTURE with write counters reinitialised.
- Qualified inputs during DRAIN are discarded (no buffer write, no counter change) and set `dropped`. `dropped` clears only on `rst`.

## Timing
- Reset values: state CAPTURE, `outValid`=0, `outputPixel`=0, `outRow`=0, `outCol`=0, `frameDone`=0, `dropped`=0.
- `rst` mid-capture or mid-drain aborts the frame immediately; no `frameDone`; partial data is discarded.
- Last qualified input sampled at edge N gives state DRAIN after N. First `outValid`=1 after edge N+2, showing pixel (0,0).
- Throughput: with `outReady` held high, `outValid` stays high for exactly ROW_SIZE*NUM_ROWS consecutive cycles.
- `outValid` never deasserts without a handshake.
- `frameDone` is high for exactly one cycle, the cycle after the final handshake.
  - A qualified input in that same cycle is captured as pixel (NUM_ROWS-1, 0) of the next frame.
- Capture accepts at most 1 pixel/cycle; no backpressure toward `convolution`.

## Test plan
Bench uses `ROW_SIZE`=4, `NUM_ROWS`=3.
- Basic reorder: 12 contiguous inputs 0x00..0x0B with `valid`=01, `outReady`=1 -> outputs 08,09,0A,0B,04,05,06,07,00,01,02,03. `outRow`/`outCol` go (0,0)..(2,3); `frameDone` pulses once.
- Invalid codes: interleave `valid`=00/10/11 cycles carrying 0xFF between the 12 pixels -> identical output sequence; 0xFF never appears.
- Backpressure: toggle `outReady` 1,0,0,1,... during drain -> each value held stable while stalled; 12 handshakes; no duplicates or skips.
- Overrun: a qualified input 0xAA during DRAIN -> `dropped`=1 and remains set; drained data unchanged. A second frame 0x10..0x1B afterwards -> 18..1B,14..17,10..13.
- Reset mid-frame: assert `rst` after 6 inputs, then send 12 fresh inputs 0x20..0x2B -> outputs 28..2B,24..27,20..23; all outputs 0 during reset.
- Back-to-back frames: second frame's first pixel 0x30 presented in the `frameDone` cycle -> it appears as output (2,0) of frame 2.
